// File: rtl/pcie_ss_ctrl_bridge.sv
// pcie_ss_ctrl_bridge: turns each subsystem-control command from the PCIe CSR
// block into exactly one Avalon-MM access to the hard-IP control port, and
// returns completion as a level ack/error that software polls.
// Optional feature: define PCIE_SS_CTRL_TIMEOUT_EN to abort accesses that do
// not complete within TIMEOUT_CYCLES cycles.
module pcie_ss_ctrl_bridge #(
    parameter int unsigned ADDR_WIDTH     = 18,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            i_ss_ctrl_cmd,
    input  logic [ADDR_WIDTH-1:0] i_ss_ctrl_addr,
    input  logic [31:0]           i_ss_ctrl_writedata,
    output logic [31:0]           o_ss_readdata,
    output logic                  o_ss_ack,
    output logic                  o_ss_error,
    output logic [ADDR_WIDTH-1:0] o_avmm_address,
    output logic                  o_avmm_read,
    output logic                  o_avmm_write,
    output logic [31:0]           o_avmm_writedata,
    output logic [3:0]            o_avmm_byteenable,
    input  logic                  i_avmm_waitrequest,
    input  logic [31:0]           i_avmm_readdata,
    input  logic                  i_avmm_readdatavalid,
    input  logic [1:0]            i_avmm_response
);

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ISSUE   = 2'b01,
        WAIT_RD = 2'b10,
        DONE    = 2'b11
    } state_t;

    state_t state;
    logic   timeout_c;

    // Elaboration-time guard on the timeout limit.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 2");
    end

`ifdef PCIE_SS_CTRL_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt;

    assign timeout_c = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Per-access cycle counter; zero whenever no access is outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == ISSUE || state == WAIT_RD) begin
            cnt <= cnt + CNT_W'(1);
        end else begin
            cnt <= '0;
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    // Command FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            o_ss_readdata     <= '0;
            o_ss_ack          <= 1'b0;
            o_ss_error        <= 1'b0;
            o_avmm_address    <= '0;
            o_avmm_read       <= 1'b0;
            o_avmm_write      <= 1'b0;
            o_avmm_writedata  <= '0;
            o_avmm_byteenable <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_ss_ctrl_cmd != CMD_IDLE) begin
                        o_avmm_address   <= i_ss_ctrl_addr;
                        o_avmm_writedata <= i_ss_ctrl_writedata;
                        o_ss_readdata    <= '0;
                        o_ss_error       <= 1'b0;
                        if (i_ss_ctrl_cmd == CMD_READ) begin
                            o_avmm_read       <= 1'b1;
                            o_avmm_byteenable <= 4'hF;
                            state             <= ISSUE;
                        end else if (i_ss_ctrl_cmd == CMD_WRITE) begin
                            o_avmm_write      <= 1'b1;
                            o_avmm_byteenable <= 4'hF;
                            state             <= ISSUE;
                        end else begin
                            // Reserved command: fail without touching the bus.
                            o_ss_error <= 1'b1;
                            o_ss_ack   <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    if (!i_avmm_waitrequest) begin
                        o_avmm_read       <= 1'b0;
                        o_avmm_write      <= 1'b0;
                        o_avmm_byteenable <= '0;
                        if (o_avmm_write) begin
                            o_ss_error <= (i_avmm_response != 2'b00);
                            o_ss_ack   <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= WAIT_RD;
                        end
                    end else if (timeout_c) begin
                        o_avmm_read       <= 1'b0;
                        o_avmm_write      <= 1'b0;
                        o_avmm_byteenable <= '0;
                        o_ss_readdata     <= 32'hFFFF_FFFF;
                        o_ss_error        <= 1'b1;
                        o_ss_ack          <= 1'b1;
                        state             <= DONE;
                    end
                end
                WAIT_RD: begin
                    if (i_avmm_readdatavalid) begin
                        o_ss_readdata <= i_avmm_readdata;
                        o_ss_error    <= (i_avmm_response != 2'b00);
                        o_ss_ack      <= 1'b1;
                        state         <= DONE;
                    end else if (timeout_c) begin
                        o_ss_readdata <= 32'hFFFF_FFFF;
                        o_ss_error    <= 1'b1;
                        o_ss_ack      <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    // Held until software returns cmd to idle, so one access per command.
                    if (i_ss_ctrl_cmd == CMD_IDLE) begin
                        o_ss_ack <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_ss_ctrl_bridge.sv
// Directed self-checking bench for pcie_ss_ctrl_bridge.
module tb_pcie_ss_ctrl_bridge;

    localparam int unsigned AW     = 18;
    localparam int unsigned TO_CYC = 16;

    logic          clk;
    logic          rst;
    logic [1:0]    cmd;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   ss_readdata;
    logic          ss_ack;
    logic          ss_error;
    logic [AW-1:0] av_address;
    logic          av_read;
    logic          av_write;
    logic [31:0]   av_writedata;
    logic [3:0]    av_byteenable;
    logic          av_waitrequest;
    logic [31:0]   av_readdata;
    logic          av_readdatavalid;
    logic [1:0]    av_response;

    int checks = 0;
    int errors = 0;
    int wr_acc = 0;
    int rd_acc = 0;
    int req_cycles = 0;

    pcie_ss_ctrl_bridge #(
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_ss_ctrl_cmd       (cmd),
        .i_ss_ctrl_addr      (addr),
        .i_ss_ctrl_writedata (wdata),
        .o_ss_readdata       (ss_readdata),
        .o_ss_ack            (ss_ack),
        .o_ss_error          (ss_error),
        .o_avmm_address      (av_address),
        .o_avmm_read         (av_read),
        .o_avmm_write        (av_write),
        .o_avmm_writedata    (av_writedata),
        .o_avmm_byteenable   (av_byteenable),
        .i_avmm_waitrequest  (av_waitrequest),
        .i_avmm_readdata     (av_readdata),
        .i_avmm_readdatavalid(av_readdatavalid),
        .i_avmm_response     (av_response)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus activity monitor: accepted transfers and request-asserted cycles.
    always @(posedge clk) begin
        if (!rst) begin
            if (av_write && !av_waitrequest) wr_acc++;
            if (av_read && !av_waitrequest) rd_acc++;
            if (av_read || av_write) req_cycles++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({ss_readdata, ss_ack, ss_error, av_address, av_read, av_write, av_writedata, av_byteenable} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rd=%h ack=%b err=%b addr=%h r=%b w=%b wd=%h be=%h, required all 0",
                     ss_readdata, ss_ack, ss_error, av_address, av_read, av_write, av_writedata, av_byteenable);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_write();
        int w0;
        w0 = wr_acc;
        cmd = 2'b10; addr = 18'h00104; wdata = 32'hCAFE_0001;
        av_waitrequest = 1'b0; av_response = 2'b00;
        step();
        checks++;
        if ({av_write, av_read, av_address, av_writedata, av_byteenable, ss_ack} !== {1'b1, 1'b0, 18'h00104, 32'hCAFE_0001, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL write_request: got w=%b r=%b addr=%h wd=%h be=%h ack=%b, required w=1 r=0 addr=00104 wd=cafe0001 be=f ack=0",
                     av_write, av_read, av_address, av_writedata, av_byteenable, ss_ack);
        end
        step();
        checks++;
        if ({av_write, av_byteenable, ss_ack, ss_error} !== {1'b0, 4'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL write_complete: got w=%b be=%h ack=%b err=%b, required w=0 be=0 ack=1 err=0",
                     av_write, av_byteenable, ss_ack, ss_error);
        end
        step();
        step();
        checks++;
        if (ss_ack !== 1'b1 || (wr_acc - w0) != 1) begin
            errors++;
            $display("FAIL write_hold_ack: got ack=%b writes=%0d, required ack=1 writes=1", ss_ack, wr_acc - w0);
        end
        cmd = 2'b00;
        step();
        checks++;
        if (ss_ack !== 1'b0) begin
            errors++;
            $display("FAIL write_ack_clear: got ack=%b, required 0", ss_ack);
        end
    endtask

    task automatic test_read_stall();
        int bad;
        int r0;
        bad = 0;
        r0 = rd_acc;
        cmd = 2'b01; addr = 18'h2ABCD; wdata = 32'h0;
        av_waitrequest = 1'b1; av_readdatavalid = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            if (av_read !== 1'b1 || av_address !== 18'h2ABCD || av_byteenable !== 4'hF) bad++;
            addr = 18'h00000;
            av_waitrequest = (i < 3);
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL read_held: got %0d bad cycles of 4, required 0", bad);
        end
        checks++;
        if ({av_read, av_byteenable, ss_ack} !== {1'b0, 4'h0, 1'b0} || (rd_acc - r0) != 1) begin
            errors++;
            $display("FAIL read_accept: got r=%b be=%h ack=%b accepts=%0d, required r=0 be=0 ack=0 accepts=1",
                     av_read, av_byteenable, ss_ack, rd_acc - r0);
        end
        step();
        av_readdatavalid = 1'b1; av_readdata = 32'h1234_5678; av_response = 2'b00;
        step();
        av_readdatavalid = 1'b0;
        checks++;
        if ({ss_ack, ss_error, ss_readdata} !== {1'b1, 1'b0, 32'h1234_5678}) begin
            errors++;
            $display("FAIL read_result: got ack=%b err=%b data=%h, required ack=1 err=0 data=12345678",
                     ss_ack, ss_error, ss_readdata);
        end
        cmd = 2'b00;
        step();
        checks++;
        if (ss_ack !== 1'b0 || ss_readdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL read_hold_data: got ack=%b data=%h, required ack=0 data=12345678", ss_ack, ss_readdata);
        end
    endtask

    task automatic test_error_response();
        cmd = 2'b01; addr = 18'h00010;
        av_waitrequest = 1'b0;
        step();
        step();
        checks++;
        if (ss_ack !== 1'b0 || av_read !== 1'b0) begin
            errors++;
            $display("FAIL err_wait_rd: got ack=%b r=%b, required ack=0 r=0", ss_ack, av_read);
        end
        av_readdatavalid = 1'b1; av_readdata = 32'hDEAD_BEEF; av_response = 2'b10;
        step();
        av_readdatavalid = 1'b0; av_response = 2'b00;
        checks++;
        if ({ss_ack, ss_error, ss_readdata} !== {1'b1, 1'b1, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL err_result: got ack=%b err=%b data=%h, required ack=1 err=1 data=deadbeef",
                     ss_ack, ss_error, ss_readdata);
        end
        cmd = 2'b00;
        step();
        checks++;
        if (ss_error !== 1'b1) begin
            errors++;
            $display("FAIL err_hold: got err=%b, required 1", ss_error);
        end
        cmd = 2'b10; addr = 18'h00020; wdata = 32'h5;
        step();
        checks++;
        if (ss_error !== 1'b0 || ss_readdata !== 32'h0) begin
            errors++;
            $display("FAIL err_clear: got err=%b data=%h, required err=0 data=0", ss_error, ss_readdata);
        end
        step();
        cmd = 2'b00;
        step();
    endtask

    task automatic test_reserved();
        int q0;
        q0 = req_cycles;
        cmd = 2'b11; addr = 18'h00333;
        step();
        checks++;
        if ({ss_ack, ss_error, av_read, av_write} !== {1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reserved_done: got ack=%b err=%b r=%b w=%b, required ack=1 err=1 r=0 w=0",
                     ss_ack, ss_error, av_read, av_write);
        end
        step();
        step();
        cmd = 2'b00;
        step();
        checks++;
        if (ss_ack !== 1'b0 || req_cycles != q0) begin
            errors++;
            $display("FAIL reserved_no_bus: got ack=%b req_cycles=%0d, required ack=0 req_cycles=0",
                     ss_ack, req_cycles - q0);
        end
    endtask

    task automatic test_held_cmd();
        int w0;
        w0 = wr_acc;
        cmd = 2'b10; addr = 18'h00444; wdata = 32'h4444;
        av_waitrequest = 1'b0;
        for (int i = 0; i < 50; i++) step();
        checks++;
        if ((wr_acc - w0) != 1 || ss_ack !== 1'b1) begin
            errors++;
            $display("FAIL held_single_write: got writes=%0d ack=%b, required writes=1 ack=1", wr_acc - w0, ss_ack);
        end
        cmd = 2'b00;
        step();
        // Command withdrawn mid-read: access completes, ack pulses once.
        cmd = 2'b01; addr = 18'h00555;
        av_waitrequest = 1'b1;
        step();
        cmd = 2'b00; addr = 18'h3FFFF;
        step();
        step();
        checks++;
        if (av_read !== 1'b1 || av_address !== 18'h00555) begin
            errors++;
            $display("FAIL drop_read_held: got r=%b addr=%h, required r=1 addr=00555", av_read, av_address);
        end
        av_waitrequest = 1'b0;
        step();
        step();
        av_readdatavalid = 1'b1; av_readdata = 32'hA5A5_5A5A;
        step();
        av_readdatavalid = 1'b0;
        checks++;
        if (ss_ack !== 1'b1 || ss_readdata !== 32'hA5A5_5A5A) begin
            errors++;
            $display("FAIL drop_ack_pulse: got ack=%b data=%h, required ack=1 data=a5a55a5a", ss_ack, ss_readdata);
        end
        step();
        checks++;
        if (ss_ack !== 1'b0) begin
            errors++;
            $display("FAIL drop_ack_single: got ack=%b, required 0", ss_ack);
        end
        // Stray readdatavalid while idle must not disturb results.
        av_readdatavalid = 1'b1; av_readdata = 32'h0BAD_0BAD; av_response = 2'b11;
        step();
        av_readdatavalid = 1'b0; av_response = 2'b00;
        checks++;
        if ({ss_ack, ss_error, ss_readdata} !== {1'b0, 1'b0, 32'hA5A5_5A5A}) begin
            errors++;
            $display("FAIL stray_rdv: got ack=%b err=%b data=%h, required ack=0 err=0 data=a5a55a5a",
                     ss_ack, ss_error, ss_readdata);
        end
    endtask

`ifdef PCIE_SS_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int bad;
        bad = 0;
        cmd = 2'b01; addr = 18'h00666;
        av_waitrequest = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            if (av_read !== 1'b1) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_held: got %0d cycles without read of 16, required 0", bad);
        end
        checks++;
        if ({av_read, ss_ack, ss_error, ss_readdata} !== {1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL timeout_abort: got r=%b ack=%b err=%b data=%h, required r=0 ack=1 err=1 data=ffffffff",
                     av_read, ss_ack, ss_error, ss_readdata);
        end
        cmd = 2'b00; av_waitrequest = 1'b0;
        step();
    endtask
`else
    task automatic test_no_timeout();
        cmd = 2'b01; addr = 18'h00666;
        av_waitrequest = 1'b1;
        step();
        for (int i = 0; i < 40; i++) step();
        checks++;
        if (av_read !== 1'b1 || ss_ack !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout_wait: got r=%b ack=%b, required r=1 ack=0", av_read, ss_ack);
        end
        av_waitrequest = 1'b0;
        step();
        av_readdatavalid = 1'b1; av_readdata = 32'h0000_0666;
        step();
        av_readdatavalid = 1'b0;
        cmd = 2'b00;
        step();
    endtask
`endif

    task automatic test_reset_mid_access();
        cmd = 2'b01; addr = 18'h00777;
        av_waitrequest = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        checks++;
        if ({ss_readdata, ss_ack, ss_error, av_address, av_read, av_write, av_writedata, av_byteenable} !== '0) begin
            errors++;
            $display("FAIL reset_mid_access: got r=%b w=%b be=%h ack=%b addr=%h, required all 0",
                     av_read, av_write, av_byteenable, ss_ack, av_address);
        end
        rst = 1'b0; cmd = 2'b00; av_waitrequest = 1'b0;
        step();
        checks++;
        if (av_read !== 1'b0 || ss_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_reissue: got r=%b ack=%b, required r=0 ack=0", av_read, ss_ack);
        end
    endtask

    initial begin
        rst = 1'b1; cmd = 2'b00; addr = '0; wdata = '0;
        av_waitrequest = 1'b0; av_readdata = '0; av_readdatavalid = 1'b0; av_response = 2'b00;
        test_reset();
        test_write();
        test_read_stall();
        test_error_response();
        test_reserved();
        test_held_cmd();
`ifdef PCIE_SS_CTRL_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcie_ss_ctrl_bridge.md
Name: pcie_ss_ctrl_bridge

Overview:
- Downstream consumer of the PCIe CSR block's subsystem-control command interface (cmd/addr/writedata out, readdata/ack/error back).
- Converts each software-issued command into exactly one Avalon-MM access to the PCIe hard-IP control/config register port.
- Returns completion status as a level ack/error handshake that software polls through the CSR.

Parameters:
- ADDR_WIDTH, 18, width of the subsystem control address.
- TIMEOUT_CYCLES, 1024, cycles allowed per access before it is aborted. Only used with PCIE_SS_CTRL_TIMEOUT_EN. Must be >=2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_ss_ctrl_cmd  in  2  00 idle, 01 read, 10 write, 11 reserved.
- i_ss_ctrl_addr  in  ADDR_WIDTH  access address.
- i_ss_ctrl_writedata  in  32  write data.
- o_ss_readdata  out  32  read result.
- o_ss_ack  out  1  command complete; level.
- o_ss_error  out  1  command failed; valid while o_ss_ack=1.
- o_avmm_address  out  ADDR_WIDTH  Avalon address.
- o_avmm_read  out  1  Avalon read request.
- o_avmm_write  out  1  Avalon write request.
- o_avmm_writedata  out  32  Avalon write data.
- o_avmm_byteenable  out  4  constant 4'hF while a request is asserted, else 0.
- i_avmm_waitrequest  in  1  slave stall.
- i_avmm_readdata  in  32  read data.
- i_avmm_readdatavalid  in  1  read data strobe.
- i_avmm_response  in  2  00 OKAY; any other value is an error. Sampled with readdatavalid, or at write acceptance.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All outputs are registered.
- Reset: state IDLE; every output 0. A reset mid-access abandons the access and deasserts read/write on the next edge.
- FSM states: IDLE, ISSUE, WAIT_RD, DONE.
- IDLE, cmd!=00 sampled:
  - capture addr and writedata;
  - clear o_ss_readdata to 0 and o_ss_error to 0.
- IDLE, next state by cmd:
  - 01 or 10: go to ISSUE. o_avmm_read or o_avmm_write is 1 in the cycle after sampling.
  - 11: go to DONE with error=1. No bus access.
- ISSUE:
  - Hold the request and address/data stable while waitrequest=1.
  - Acceptance is the cycle with waitrequest=0. The request deasserts on the next edge.
  - Write accepted: go to DONE. error = (response!=00).
  - Read accepted: go to WAIT_RD.
  - readdatavalid is ignored in ISSUE. The slave returns data at least 1 cycle after acceptance.
- WAIT_RD, on readdatavalid:
  - o_ss_readdata <= readdata;
  - error = (response!=00);
  - go to DONE.
- DONE:
  - o_ss_ack=1.
  - Stay while cmd!=00; go to IDLE on the first cycle cmd==00. o_ss_ack clears on that edge.
  - readdata and error hold until the next command is accepted.
- One access per command: a held nonzero cmd never re-issues.
- Changes to cmd/addr/data while in ISSUE/WAIT_RD are ignored.
- cmd dropping to 00 mid-access:
  - the access still completes;
  - DONE lasts exactly 1 cycle (ack pulse);
  - then the FSM returns to IDLE.
- Stray readdatavalid in IDLE/DONE: ignored.
- Minimum latency:
  - write: cmd sampled at edge N, write asserted N+1, accepted N+1, ack=1 at N+2;
  - read with 1-cycle data return: ack=1 at N+3.

Optional Feature:
- Macro: PCIE_SS_CTRL_TIMEOUT_EN.
- With the macro:
  - cycle counter cleared on entry to ISSUE; increments every cycle in ISSUE/WAIT_RD;
  - when the count reaches TIMEOUT_CYCLES-1 without completion: deassert read/write next edge, go to DONE, error=1, o_ss_readdata=32'hFFFF_FFFF;
  - completion in the same cycle as the limit takes priority (normal result).
- Without the macro: no counter; ISSUE/WAIT_RD wait indefinitely.

Test Plan:
- Write: cmd=10, addr=18'h00104, data=32'hCAFE_0001, waitrequest low -> one write pulse with those values, byteenable=F; ack=1 two cycles later, error=0; ack clears after cmd=00.
- Read with stall: cmd=01, waitrequest high 3 cycles, readdata=32'h1234_5678 two cycles after accept -> read held 4 cycles; o_ss_readdata=32'h1234_5678, ack=1, error=0.
- Error response: read returning response=2'b10 -> ack=1, error=1, readdata latched. The next command clears error.
- Reserved cmd=11 -> no read/write ever asserted; ack=1, error=1 one cycle after sampling.
- Held cmd: cmd=10 held 50 cycles -> exactly one write. cmd dropped mid-read -> single-cycle ack pulse.
- Timeout (macro on, TIMEOUT_CYCLES=16): waitrequest stuck high -> read deasserted after 16 cycles; ack=1, error=1, readdata=32'hFFFF_FFFF. Reset asserted mid-access -> all outputs 0 next cycle.
